// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state type and
// the lane/legality helpers used by the memory controller.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_RESP
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return !off[0];
            F3_W:        return off == 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            F3_B:    return {4{w[7:0]}};
            F3_H:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request interface (control FSM <-> LSU) and data-memory bus interface
// (LSU <-> memory) for the load/store controller.
interface lsu_req_if;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (output start, we, funct3, addr, wdata,
                    input  busy, done, err, rdata);
    modport slave  (input  start, we, funct3, addr, wdata,
                    output busy, done, err, rdata);
endinterface

interface lsu_mem_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a bus word and sign- or zero-extends it.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: one-shot request -> valid/ready bus access.
// Define LSU_MISALIGN_TRAP_EN to make misaligned half/word accesses illegal.
module lsu_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    lsu_req_if.slave        req,
    lsu_mem_if.master       mem
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic        access_ok;
    logic [31:0] ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign access_ok = f3_legal(req.we, req.funct3) && f3_aligned(req.funct3, req.addr[1:0]);
`else
    assign access_ok = f3_legal(req.we, req.funct3);
`endif

    assign cnt_inc = cnt_q + 8'd1;

    lsu_load_align u_align (
        .word_i   (mem.mem_rdata),
        .off_i    (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LSU_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (req.start) begin
                    we_d    = req.we;
                    f3_d    = req.funct3;
                    addr_d  = req.addr;
                    wdata_d = req.wdata;
                    cnt_d   = '0;
                    if (access_ok) begin
                        err_d   = 1'b0;
                        state_d = LSU_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = LSU_RESP;
                    end
                end
            end
            LSU_ACCESS: begin
                // mem_ready wins over a timeout landing in the same cycle
                if (mem.mem_ready) begin
                    if (!we_q) rdata_d = ld_data;
                    state_d = LSU_RESP;
                end else if (cnt_inc == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = LSU_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        req.busy      = state_q != LSU_IDLE;
        req.done      = state_q == LSU_RESP;
        req.err       = (state_q == LSU_RESP) && err_q;
        req.rdata     = rdata_q;
        mem.mem_valid = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = '0;
        mem.mem_wdata = '0;
        if (state_q == LSU_ACCESS) begin
            mem.mem_valid = 1'b1;
            mem.mem_we    = we_q;
            mem.mem_addr  = {addr_q[31:2], 2'b00};
            mem.mem_be    = we_q ? store_be(f3_q, addr_q[1:0]) : 4'hF;
            mem.mem_wdata = we_q ? store_data(f3_q, wdata_q) : '0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (TIMEOUT overridden to 4).
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_req_if req_if();
    lsu_mem_if mem_if();

    lsu_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .req (req_if.slave),
        .mem (mem_if.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic        bus;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mrd, input logic bus,
                                input logic [3:0] be, input logic [31:0] baddr, input logic [31:0] bwdata,
                                input logic err, input logic chk_rd, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrd = mrd; v.bus = bus;
        v.be = be; v.baddr = baddr; v.bwdata = bwdata; v.err = err; v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [69:0] bus_snap();
        return {mem_if.mem_valid, mem_if.mem_we, mem_if.mem_be, mem_if.mem_addr, mem_if.mem_wdata};
    endfunction

    task automatic drive_start(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
        req_if.start  = 1'b1;
        req_if.we     = we;
        req_if.funct3 = f3;
        req_if.addr   = addr;
        req_if.wdata  = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        drive_start(v.we, v.f3, v.addr, v.wdata);
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = v.mrd;
        @(posedge clk); #1;
        req_if.start = 1'b0;
        if (v.bus) begin
            check($sformatf("v%0d_bus", idx), 128'(bus_snap()), 128'({1'b1, v.we, v.be, v.baddr, v.bwdata}));
            check($sformatf("v%0d_nodone", idx), 128'(req_if.done), 128'(0));
            @(posedge clk); #1;
        end else begin
            check($sformatf("v%0d_novalid", idx), 128'(mem_if.mem_valid), 128'(0));
        end
        check($sformatf("v%0d_busy_done_err", idx), 128'({req_if.busy, req_if.done, req_if.err}),
              128'({2'b11, v.err}));
        if (v.chk_rd) check($sformatf("v%0d_rdata", idx), 128'(req_if.rdata), 128'(v.rd));
    endtask

    initial begin
        int vcnt;
        int dcnt;
        logic got_done;

        req_if.start = 1'b0; req_if.we = 1'b0; req_if.funct3 = '0;
        req_if.addr = '0; req_if.wdata = '0;
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = '0;

        //        we  f3      addr          wdata         mrd          bus be       baddr         bwdata        err chk rd
        vecs[0]  = mk(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 4'hF,    32'h100, 32'h0,        0, 1, 32'hDEADBEEF);
        vecs[1]  = mk(0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1, 4'hF,    32'h100, 32'h0,        0, 1, 32'hFFFFFF80);
        vecs[2]  = mk(0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 1, 4'hF,    32'h100, 32'h0,        0, 1, 32'h00000080);
        vecs[3]  = mk(1, 3'b000, 32'h102, 32'h000000A5, 32'h0,        1, 4'b0100, 32'h100, 32'hA5A5A5A5, 0, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[4]  = mk(0, 3'b001, 32'h101, 32'h0,        32'h12348765, 0, 4'h0,    32'h0,   32'h0,        1, 1, 32'h0);
`else
        vecs[4]  = mk(0, 3'b001, 32'h101, 32'h0,        32'h12348765, 1, 4'hF,    32'h100, 32'h0,        0, 1, 32'hFFFF8765);
`endif
        vecs[5]  = mk(0, 3'b101, 32'h102, 32'h0,        32'h12348765, 1, 4'hF,    32'h100, 32'h0,        0, 1, 32'h00001234);
        vecs[6]  = mk(1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0,        1, 4'b1100, 32'h100, 32'hBEEFBEEF, 0, 0, 32'h0);
        vecs[7]  = mk(1, 3'b010, 32'h200, 32'h01234567, 32'h0,        1, 4'hF,    32'h200, 32'h01234567, 0, 0, 32'h0);
        vecs[8]  = mk(0, 3'b011, 32'h100, 32'h0,        32'h55555555, 0, 4'h0,    32'h0,   32'h0,        1, 1, 32'h0);
        vecs[9]  = mk(1, 3'b100, 32'h100, 32'h000000FF, 32'h0,        0, 4'h0,    32'h0,   32'h0,        1, 0, 32'h0);
        vecs[10] = mk(0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 4'hF,    32'h100, 32'h0,        0, 1, 32'h0000007F);
        vecs[11] = mk(0, 3'b001, 32'h100, 32'h0,        32'h00008001, 1, 4'hF,    32'h100, 32'h0,        0, 1, 32'hFFFF8001);

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_req", 128'({req_if.busy, req_if.done, req_if.err, req_if.rdata}), 128'(0));
        check("rst_bus", 128'(bus_snap()), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Wait states: mem_ready low for 3 cycles
        @(posedge clk); #1;
        drive_start(0, 3'b010, 32'h300, 32'h0);
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_if.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ws_stable%0d", i), 128'({bus_snap(), req_if.done}),
                  128'({1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0}));
            @(posedge clk); #1;
        end
        mem_if.mem_ready = 1'b1;
        check("ws_last", 128'({bus_snap(), req_if.done}), 128'({1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0}));
        @(posedge clk); #1;
        check("ws_done", 128'({req_if.done, req_if.err, mem_if.mem_valid, req_if.rdata}),
              128'({1'b1, 1'b0, 1'b0, 32'hCAFEF00D}));

        // Timeout with TIMEOUT=4
        @(posedge clk); #1;
        drive_start(0, 3'b010, 32'h400, 32'h0);
        mem_if.mem_ready = 1'b0;
        vcnt = 0;
        got_done = 1'b0;
        @(posedge clk); #1;
        req_if.start = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (req_if.done) got_done = 1'b1;
            else begin
                if (mem_if.mem_valid) vcnt++;
                @(posedge clk); #1;
            end
        end
        check("to_done_seen", 128'(got_done), 128'(1));
        check("to_valid_cycles", 128'(vcnt), 128'(4));
        check("to_err_rdata", 128'({req_if.err, req_if.rdata}), 128'({1'b1, 32'h0}));

        // Reset in ACCESS
        @(posedge clk); #1;
        drive_start(0, 3'b010, 32'h100, 32'h0);
        @(posedge clk); #1;
        req_if.start = 1'b0;
        check("ra_valid", 128'(mem_if.mem_valid), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("ra_drop", 128'({mem_if.mem_valid, req_if.busy}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mem_if.mem_ready = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_if.done) dcnt++;
            @(posedge clk); #1;
        end
        check("ra_no_done", 128'(dcnt), 128'(0));
        run_vec(vecs[0], 100);

        // start during busy and start coincident with done are ignored
        @(posedge clk); #1;
        drive_start(0, 3'b010, 32'h500, 32'h0);
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'h11112222;
        @(posedge clk); #1;
        drive_start(1, 3'b010, 32'h600, 32'h99999999);
        @(posedge clk); #1;
        req_if.start = 1'b0;
        check("sb_bus_kept", 128'(bus_snap()), 128'({1'b1, 1'b0, 4'hF, 32'h500, 32'h0}));
        mem_if.mem_ready = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req_if.start = 1'b0;
            if (req_if.done) begin
                dcnt++;
                check("sb_rdata", 128'({req_if.err, req_if.rdata}), 128'({1'b0, 32'h11112222}));
                drive_start(0, 3'b010, 32'h700, 32'h0);
                @(posedge clk); #1;
                req_if.start = 1'b0;
                check("sd_ignored", 128'({req_if.busy, mem_if.mem_valid}), 128'(0));
            end
        end
        check("sb_one_done", 128'(dcnt), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
